// File: rtl/morse_pkg.sv
// Shared ASCII constants and character-class helpers for the Morse datapath.
package morse_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;

  // Non-printing characters: C0 controls and DEL have no Morse symbol.
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b < ASCII_SPACE) || (b == ASCII_DEL);
  endfunction

endpackage

// File: rtl/morse_fifo_mem.sv
// DEPTH x 8 storage: synchronous write, registered read, no reset so it maps to block RAM.
// Read data updates only on i_Rd_En and returns the old word on a same-address write.
module morse_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Wr_En,
  input  logic [AW-1:0] i_Wr_Addr,
  input  logic [7:0]    i_Wr_Data,
  input  logic          i_Rd_En,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [7:0]    o_Rd_Data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) mem_q[i_Wr_Addr] <= i_Wr_Data;
    if (i_Rd_En) rd_data_q <= mem_q[i_Rd_Addr];
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/morse_rx_fifo.sv
// Byte FIFO from UART receiver to Morse control FSM; pop request -> o_Rd_DV one cycle later.
// Writes while full are dropped and flagged sticky in o_Overflow unless a pop frees the slot.
module morse_rx_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit DROP_CTRL = 1'b1
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst,
  input  logic                       i_Wr_DV,
  input  logic [7:0]                 i_Wr_Byte,
  input  logic                       i_Rd_Req,
  output logic                       o_Rd_DV,
  output logic [7:0]                 o_Rd_Byte,
  output logic                       o_Empty,
  output logic                       o_Full,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic                       o_Overflow,
  input  logic                       i_Clr_Ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic          ovf_q, ovf_d;
  logic          rd_dv_q;
  logic          rd_seen_q;
  logic [7:0]    mem_rd_dat;

  logic filtered, wr_ok, rd_ok, wr_acc, wr_drop;

  assign filtered = DROP_CTRL && is_ctrl(i_Wr_Byte);
  assign wr_ok    = i_Wr_DV & ~filtered;
  assign rd_ok    = i_Rd_Req & ~empty_q;
  // A simultaneous pop frees a slot, so a write into a full FIFO still lands.
  assign wr_acc   = wr_ok & (~full_q | rd_ok);
  assign wr_drop  = wr_ok & full_q & ~rd_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_drop)        ovf_d = 1'b1;
    else if (i_Clr_Ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_dv_q   <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == FULL_CNT);
      ovf_q     <= ovf_d;
      rd_dv_q   <= rd_ok;
      rd_seen_q <= rd_seen_q | rd_ok;
    end
  end

  morse_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_Clock   (i_Clock),
    .i_Wr_En   (wr_acc),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_Data (i_Wr_Byte),
    .i_Rd_En   (rd_ok),
    .i_Rd_Addr (rd_ptr_q),
    .o_Rd_Data (mem_rd_dat)
  );

  // The RAM read register has no reset; mask it until the first pop since reset.
  assign o_Rd_Byte  = rd_seen_q ? mem_rd_dat : 8'h00;
  assign o_Rd_DV    = rd_dv_q;
  assign o_Empty    = empty_q;
  assign o_Full     = full_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_morse_rx_fifo.sv
// Scoreboard bench: a filtering FIFO and a non-filtering FIFO share clock, reset and write data.
module tb_morse_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_dv = 1'b0, wr_dv2 = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       rd_req = 1'b0, rd_req2 = 1'b0;
  logic       clr_ovf = 1'b0, clr_ovf2 = 1'b0;

  logic       rd_dv, rd_dv2;
  logic [7:0] rd_byte, rd_byte2;
  logic       empty, empty2, full, full2, ovf, ovf2;
  logic [4:0] count, count2;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 clk = ~clk;

  morse_rx_fifo #(.DEPTH(16), .DROP_CTRL(1'b1)) dut (
    .i_Clock(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .i_Rd_Req(rd_req), .o_Rd_DV(rd_dv), .o_Rd_Byte(rd_byte),
    .o_Empty(empty), .o_Full(full), .o_Count(count),
    .o_Overflow(ovf), .i_Clr_Ovf(clr_ovf)
  );

  morse_rx_fifo #(.DEPTH(16), .DROP_CTRL(1'b0)) dut_nf (
    .i_Clock(clk), .i_Rst(rst), .i_Wr_DV(wr_dv2), .i_Wr_Byte(wr_byte),
    .i_Rd_Req(rd_req2), .o_Rd_DV(rd_dv2), .o_Rd_Byte(rd_byte2),
    .o_Empty(empty2), .o_Full(full2), .o_Count(count2),
    .o_Overflow(ovf2), .i_Clr_Ovf(clr_ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_dv = 1'b1; wr_byte = b;
    tick();
    wr_dv = 1'b0;
  endtask

  task automatic wr_both(input logic [7:0] b);
    wr_dv = 1'b1; wr_dv2 = 1'b1; wr_byte = b;
    tick();
    wr_dv = 1'b0; wr_dv2 = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_req = 1'b1;
    repeat (n) tick();
    rd_req = 1'b0;
  endtask

  // Monitor: every popped byte must match the oldest outstanding expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rd_dv) begin
        if (exp_q.size() == 0) chk("unexpected_pop", {24'h0, rd_byte}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("pop_byte", {24'h0, rd_byte}, {24'h0, e});
        end
      end
      if (!rst && rd_dv2) begin
        if (exp2_q.size() == 0) chk("unexpected_pop_nf", {24'h0, rd_byte2}, 32'hFFFF_FFFF);
        else begin
          e = exp2_q.pop_front();
          chk("pop_byte_nf", {24'h0, rd_byte2}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_dv", rd_dv, 0); chk("rst_byte", rd_byte, 8'h00); chk("rst_ovf", ovf, 0);

    // S O S, then a 3-cycle pop burst
    wr(8'h53); wr(8'h4F); wr(8'h53);
    chk("sos_count", count, 3);
    exp_q.push_back(8'h53); exp_q.push_back(8'h4F); exp_q.push_back(8'h53);
    pop_n(3);
    chk("sos_empty", empty, 1); chk("sos_count0", count, 0);
    tick();
    chk("sos_dv_low", rd_dv, 0); chk("sos_byte_held", rd_byte, 8'h53);

    // overflow on the 17th byte
    for (int i = 0; i < 17; i++) wr(8'h41 + 8'(i));
    chk("ovf_full", full, 1); chk("ovf_set", ovf, 1); chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h41 + 8'(i));
    pop_n(16);
    chk("ovf_drained", empty, 1); chk("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // write and pop together while full
    for (int i = 0; i < 16; i++) wr(8'h61 + 8'(i));
    chk("full2_full", full, 1);
    wr_dv = 1'b1; wr_byte = 8'h5A; rd_req = 1'b1; exp_q.push_back(8'h61);
    tick();
    wr_dv = 1'b0; rd_req = 1'b0;
    chk("wrrd_full_count", count, 16); chk("wrrd_full_full", full, 1); chk("wrrd_full_ovf", ovf, 0);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h61 + 8'(i));
    exp_q.push_back(8'h5A);
    pop_n(16);
    chk("wrrd_full_drained", empty, 1);

    // control character filter vs. pass-through instance
    wr_both(8'h0D); wr_both(8'h0A); wr_both(8'h45); wr_both(8'h7F);
    chk("filt_count", count, 1); chk("nofilt_count", count2, 4);
    exp_q.push_back(8'h45);
    exp2_q.push_back(8'h0D); exp2_q.push_back(8'h0A); exp2_q.push_back(8'h45); exp2_q.push_back(8'h7F);
    rd_req = 1'b1; rd_req2 = 1'b1;
    repeat (4) tick();
    rd_req = 1'b0; rd_req2 = 1'b0;
    chk("filt_empty", empty, 1); chk("nofilt_empty", empty2, 1);

    // 40 interleaved writes/pops, pointers wrap more than twice
    for (int i = 0; i < 40; i++) begin
      wr(8'h20 + 8'(i));
      exp_q.push_back(8'h20 + 8'(i));
      pop_n(1);
    end
    tick();
    chk("wrap_empty", empty, 1);

    // pop requests while empty are ignored
    rd_req = 1'b1;
    tick(); chk("empty_req_dv1", rd_dv, 0);
    tick(); chk("empty_req_dv2", rd_dv, 0);
    rd_req = 1'b0;

    // write plus request while empty: no fall-through
    wr_dv = 1'b1; wr_byte = 8'h45; rd_req = 1'b1;
    tick();
    wr_dv = 1'b0;
    chk("nofall_dv", rd_dv, 0); chk("nofall_empty", empty, 0);
    exp_q.push_back(8'h45);
    tick();
    rd_req = 1'b0;
    chk("nofall_next_dv", rd_dv, 1); chk("nofall_next_byte", rd_byte, 8'h45);
    tick();

    // asynchronous reset with 5 entries stored
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    chk("pre_rst_count", count, 5);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_full", full, 0);
    chk("arst_dv", rd_dv, 0); chk("arst_byte", rd_byte, 8'h00); chk("arst_ovf", ovf, 0);
    tick(); tick();
    rst = 1'b0;
    wr(8'h77);
    chk("post_rst_count", count, 1);
    exp_q.push_back(8'h77);
    pop_n(1);
    tick(); tick();
    chk("post_rst_empty", empty, 1);

    wait_cnt = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    chk("outstanding_pops", exp_q.size() + exp2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
